// File: rtl/jserial_add_seq.sv
// -----------------------------------------------------------------------------
// jserial_add_seq
// Sequencer that drives a bit-serial adder core from a parallel client.
// A request hands over two WIDTH-bit operands and a carry-in. The sequencer
// clears the adder for one cycle, then feeds it one operand bit pair per cycle,
// LSB first. It collects the returned sum bits into a parallel result and
// presents sum and carry-out on a valid/ready response port.
//
// Ports
//   clk, rst             single clock, synchronous active-high reset
//   req_valid/req_ready  request handshake; operands req_a, req_b, req_cin
//   rsp_valid/rsp_ready  response handshake; result rsp_sum, rsp_cout
//   sa_rst               clear to the serial adder (also high during rst)
//   sa_en                adder consumes sa_a/sa_b this cycle
//   sa_a, sa_b, sa_cin   current operand bits and the latched carry-in
//   sa_sum, sa_cout      combinational sum / carry of the current bit
// -----------------------------------------------------------------------------
module jserial_add_seq #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_cin,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             sa_rst,
   output logic             sa_en,
   output logic             sa_a,
   output logic             sa_b,
   output logic             sa_cin,
   input  logic             sa_sum,
   input  logic             sa_cout
);

   localparam int CNTW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLR   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic             cin_q, cin_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             cout_q, cout_d;

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         cin_q   <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         cin_q   <= cin_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         cout_q  <= cout_d;
      end
   end

   // Next-state logic. During SHIFT the operands move right so bit 0 is always
   // the bit being added, and each sum bit enters the result at the MSB so that
   // after WIDTH shifts the first (LSB) sum bit has reached bit 0.
   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      cin_d   = cin_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               opa_d   = req_a;
               opb_d   = req_b;
               cin_d   = req_cin;
               cnt_d   = '0;
               res_d   = '0;
               state_d = CLR;
            end
         end
         CLR: begin
            state_d = SHIFT;
         end
         SHIFT: begin
            opa_d              = opa_q >> 1;
            opb_d              = opb_q >> 1;
            res_d              = res_q >> 1;
            res_d[WIDTH-1]     = sa_sum;
            cnt_d              = cnt_q + CNTW'(1);
            if (cnt_q == CNTW'(WIDTH - 1)) begin
               cout_d  = sa_cout;
               state_d = DONE;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Moore outputs decoded from the state. sa_rst follows rst directly so the
   // adder is cleared for the whole time the sequencer is held in reset.
   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == DONE);
   assign rsp_sum   = res_q;
   assign rsp_cout  = cout_q;
   assign sa_rst    = rst | (state_q == CLR);
   assign sa_en     = (state_q == SHIFT);
   assign sa_a      = (state_q == SHIFT) ? opa_q[0] : 1'b0;
   assign sa_b      = (state_q == SHIFT) ? opb_q[0] : 1'b0;
   assign sa_cin    = (state_q == SHIFT) ? cin_q : 1'b0;

endmodule

// File: tb/tb_jserial_add_seq.sv
// -----------------------------------------------------------------------------
// tb_jserial_add_seq
// Directed bench for jserial_add_seq (WIDTH=4) with a behavioural serial adder
// attached to the sa_* port. Expected sums are computed by hand per vector.
// -----------------------------------------------------------------------------
module tb_jserial_add_seq;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [WIDTH-1:0] req_a = '0;
   logic [WIDTH-1:0] req_b = '0;
   logic             req_cin = 1'b0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [WIDTH-1:0] rsp_sum;
   logic             rsp_cout;
   logic             sa_rst;
   logic             sa_en;
   logic             sa_a;
   logic             sa_b;
   logic             sa_cin;
   logic             sa_sum;
   logic             sa_cout;

   int assertCount = 0;
   int failCount   = 0;

   jserial_add_seq #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .sa_rst    (sa_rst),
      .sa_en     (sa_en),
      .sa_a      (sa_a),
      .sa_b      (sa_b),
      .sa_cin    (sa_cin),
      .sa_sum    (sa_sum),
      .sa_cout   (sa_cout)
   );

   always #5 clk = ~clk;

   // Reference serial adder: the first bit after a clear uses sa_cin, later
   // bits use the carry registered from the previous bit.
   logic mCarry = 1'b0;
   logic mFirst = 1'b1;
   logic mCi;
   assign mCi     = mFirst ? sa_cin : mCarry;
   assign sa_sum  = sa_a ^ sa_b ^ mCi;
   assign sa_cout = (sa_a & sa_b) | (mCi & (sa_a ^ sa_b));

   always @(posedge clk) begin
      if (sa_rst) begin
         mFirst <= 1'b1;
         mCarry <= 1'b0;
      end else if (sa_en) begin
         mFirst <= 1'b0;
         mCarry <= sa_cout;
      end
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a request and return #1 after the accepting edge (CLR cycle).
   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic cin);
      int waited = 0;
      req_a     = a;
      req_b     = b;
      req_cin   = cin;
      req_valid = 1'b1;
      while (!req_ready && waited < 30) begin
         tick();
         waited++;
      end
      if (!req_ready) checkOutput("reqTimeout", 32'd0, 32'd1);
      tick();
      req_valid = 1'b0;
   endtask

   // Called in the CLR cycle (cycle 1 after the accept cycle). Returns the
   // cycle index at which rsp_valid was seen, SHIFT cycle count, and whether
   // sa_cin matched expCin throughout SHIFT.
   task automatic waitRsp(input logic expCin, output int lat, output int shifts,
                          output logic cinOk);
      lat    = 1;
      shifts = 0;
      cinOk  = 1'b1;
      while (!rsp_valid && lat < 30) begin
         if (sa_en) begin
            shifts++;
            if (sa_cin !== expCin) cinOk = 1'b0;
         end
         tick();
         lat++;
      end
      if (!rsp_valid) checkOutput("rspTimeout", 32'd0, 32'd1);
   endtask

   task automatic runOp(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic cin,
                        input logic [WIDTH-1:0] expSum, input logic expCout);
      int   lat;
      int   shifts;
      logic cinOk;
      applyStimulus(a, b, cin);
      checkOutput({tag, "_clrSaRst"}, 32'(sa_rst), 32'd1);
      waitRsp(cin, lat, shifts, cinOk);
      checkOutput({tag, "_latency"}, 32'(lat), 32'd6);
      checkOutput({tag, "_shifts"}, 32'(shifts), 32'd4);
      checkOutput({tag, "_cinHeld"}, 32'(cinOk), 32'd1);
      checkOutput({tag, "_sum"}, 32'(rsp_sum), 32'(expSum));
      checkOutput({tag, "_cout"}, 32'(rsp_cout), 32'(expCout));
      checkOutput({tag, "_doneSaA"}, 32'(sa_a), 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput({tag, "_validDrop"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, "_backIdle"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      int   lat;
      int   shifts;
      logic cinOk;
      int   sawValid;

      $display("[TB] jserial_add_seq directed test, WIDTH=%0d", WIDTH);

      // Reset values
      repeat (3) tick();
      checkOutput("rst_saRst", 32'(sa_rst), 32'd1);
      checkOutput("rst_reqReady", 32'(req_ready), 32'd1);
      checkOutput("rst_rspValid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_rspSum", 32'(rsp_sum), 32'd0);
      checkOutput("rst_rspCout", 32'(rsp_cout), 32'd0);
      checkOutput("rst_saEn", 32'(sa_en), 32'd0);
      checkOutput("rst_saCin", 32'(sa_cin), 32'd0);
      rst = 1'b0;
      tick();
      checkOutput("idle_saRst", 32'(sa_rst), 32'd0);

      // Basic vectors
      runOp("add5p5", 4'd5, 4'd5, 1'b0, 4'd10, 1'b0);
      runOp("add6p10", 4'd6, 4'd10, 1'b0, 4'd0, 1'b1);
      runOp("add15p0c1", 4'd15, 4'd0, 1'b1, 4'd0, 1'b1);

      // 10+5 with 5 cycles of response backpressure while 3+4 waits
      applyStimulus(4'd10, 4'd5, 1'b0);
      waitRsp(1'b0, lat, shifts, cinOk);
      checkOutput("bp_latency", 32'(lat), 32'd6);
      checkOutput("bp_sum", 32'(rsp_sum), 32'd15);
      checkOutput("bp_cout", 32'(rsp_cout), 32'd0);
      req_a     = 4'd3;
      req_b     = 4'd4;
      req_cin   = 1'b0;
      req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("bp_validHeld", 32'(rsp_valid), 32'd1);
         checkOutput("bp_sumHeld", 32'(rsp_sum), 32'd15);
         checkOutput("bp_reqBlocked", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput("b2b_validDrop", 32'(rsp_valid), 32'd0);
      checkOutput("b2b_idleReady", 32'(req_ready), 32'd1);
      checkOutput("b2b_notYetClr", 32'(sa_rst), 32'd0);
      tick();
      req_valid = 1'b0;
      checkOutput("b2b_clrSaRst", 32'(sa_rst), 32'd1);
      checkOutput("b2b_clrBusy", 32'(req_ready), 32'd0);
      waitRsp(1'b0, lat, shifts, cinOk);
      checkOutput("b2b_latency", 32'(lat), 32'd6);
      checkOutput("b2b_sum", 32'(rsp_sum), 32'd7);
      checkOutput("b2b_cout", 32'(rsp_cout), 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput("b2b_end", 32'(rsp_valid), 32'd0);

      // Reset on the 2nd SHIFT cycle of 9+9
      applyStimulus(4'd9, 4'd9, 1'b0);
      tick();
      checkOutput("mid_shift1", 32'(sa_en), 32'd1);
      tick();
      rst = 1'b1;
      #1;
      checkOutput("mid_saRst", 32'(sa_rst), 32'd1);
      tick();
      rst = 1'b0;
      #1;
      checkOutput("mid_idle", 32'(req_ready), 32'd1);
      checkOutput("mid_saEn", 32'(sa_en), 32'd0);
      checkOutput("mid_sumClr", 32'(rsp_sum), 32'd0);
      sawValid = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (rsp_valid) sawValid++;
      end
      checkOutput("mid_noRsp", 32'(sawValid), 32'd0);
      runOp("add1p2", 4'd1, 4'd2, 1'b0, 4'd3, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
